// File: rtl/multu_hilo_pkg.sv
// Shared function codes and multiplier FSM encoding for the ALU, result mux and multiplier.
package multu_hilo_pkg;

  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multu_hilo_hilo_reg.sv
// HI/LO product register with write enable and the MFHI/MFLO read mux.
module hilo_reg
  import multu_hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [2*WIDTH-1:0]   din,
  input  logic [5:0]           sel,
  output logic [WIDTH-1:0]     dout
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (wr_en) begin
      hi <= din[2*WIDTH-1:WIDTH];
      lo <= din[WIDTH-1:0];
    end
  end

  always_comb begin
    dout = '0;
    case (sel)
      FN_MFHI: dout = hi;
      FN_MFLO: dout = lo;
      default: dout = '0;
    endcase
  end

endmodule

// File: rtl/multu_hilo.sv
// Sequential shift-add unsigned multiplier (one iteration per cycle) writing HI/LO.
module multu_hilo
  import multu_hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t             state;
  state_t             state_next;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               start;
  logic               last_iter;

  assign start        = (Signal == FN_MULTU);
  assign last_iter    = (state == RUN) && (count == CW'(WIDTH - 1));
  // HI/LO capture the sum of the final iteration directly, not the product register.
  assign product_next = mplier[0] ? (product + mcand) : product;
  assign busy         = (state == RUN);
  assign done         = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      count   <= '0;
    end else if (state == IDLE && start) begin
      mcand   <= (2*WIDTH)'(dataA);
      mplier  <= dataB;
      product <= '0;
      count   <= '0;
    end else if (state == RUN) begin
      product <= product_next;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      count   <= count + 1'b1;
    end
  end

  hilo_reg #(.WIDTH(WIDTH)) u_hilo (
    .clk   (clk),
    .reset (reset),
    .wr_en (last_iter),
    .din   (product_next),
    .sel   (Signal),
    .dout  (dataOut)
  );

endmodule

// File: doc/multu_hilo.md
# multu_hilo

Sequential 32x32 unsigned multiplier with its own HI/LO result registers. It sits beside the combinational ALU and takes the same `dataA`/`dataB`/`Signal` operand bus. It executes MULTU as a 32-iteration shift-add and stores the 64-bit product in HI/LO. MFHI and MFLO read the product back onto the 32-bit result bus, which the result mux downstream selects alongside the ALU output.

## Interface
- `WIDTH`, 32: operand width. HI and LO are `WIDTH` bits each, and the product is `2*WIDTH` bits.

- `clk`  in  1  single clock; every register updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `dataA`  in  32  multiplicand, sampled only on the MULTU start edge.
- `dataB`  in  32  multiplier, sampled only on the MULTU start edge.
- `Signal`  in  6  function code: MULTU = 25, MFHI = 16, MFLO = 18. All other codes are no-ops for this block.
- `dataOut`  out  32  HI when `Signal`=MFHI, LO when `Signal`=MFLO, otherwise 0.
- `busy`  out  1  high while an iteration is in progress (RUN state).
- `done`  out  1  one-cycle pulse when HI/LO hold a new product (DONE state).

## Operation
- The state machine has three states: IDLE, RUN, DONE.
- **IDLE → RUN** when `Signal`==MULTU. On that edge:
  - multiplicand register (64 bits) ← zero-extended `dataA`
  - multiplier register (32 bits) ← `dataB`
  - product register (64 bits) ← 0
  - counter (6 bits) ← 0
- **RUN**, one iteration per cycle:
  - if multiplier[0], then product ← product + multiplicand (64-bit add, no overflow possible);
  - multiplicand ← multiplicand << 1;
  - multiplier ← multiplier >> 1;
  - counter ← counter + 1.
- **RUN → DONE** on the edge that performs iteration 32 (counter==31). On that same edge {HI,LO} ← the final product.
- **DONE → IDLE** unconditionally on the next edge.
- MULTU is accepted only in IDLE. A MULTU in RUN or DONE is ignored and does not queue.
  - If `Signal` is held at MULTU, the next operation starts on the first edge back in IDLE.
- `dataA`/`dataB` changes after the start edge have no effect on the running operation.
- HI/LO change only on the RUN→DONE edge or on reset. MFHI/MFLO during RUN return the previous product.
- `dataOut` is a combinational select of HI/LO from `Signal`. The downstream mux registers it.

## Timing
- Reset values:
  - state = IDLE
  - HI = LO = 0
  - product, multiplicand, multiplier and counter = 0
  - `busy` = 0, `done` = 0
  - `dataOut` = 0 for any `Signal`
- Reset during RUN or DONE returns the block to IDLE on that edge. The partial product is discarded, HI/LO are cleared and `done` does not pulse.
- Reset has priority over a simultaneous MULTU.
- Latency, with E0 as the start edge:
  - `busy`=1 for the 32 cycles following E0;
  - HI/LO are written at E32;
  - `done`=1 in the cycle following E32;
  - the block is IDLE again after E33.
- With `Signal` held at MULTU, a new operation starts at E34. The issue interval is 34 cycles.
- `busy` and `done` are decoded from registered state and are never high together.

## Structure
- A shared package holds the function-code constants FN_AND=36, FN_OR=37, FN_ADD=32, FN_SUB=34, FN_SLT=42, FN_MULTU=25, FN_MFHI=16 and FN_MFLO=18, plus the state encoding (IDLE, RUN, DONE).
- The ALU and the result mux use the same package.
- Sub-module `hilo_reg`: a 64-bit register with synchronous active-high reset and a write enable, plus the MFHI/MFLO read mux.
  - The multiplier datapath and FSM stay in `multu_hilo`.
  - Inputs to `hilo_reg`: the write enable, which is the RUN→DONE edge, and the final product.

## Test plan
- **Reset:** assert reset 2 cycles, then Signal=MFHI and Signal=MFLO → `dataOut`=0 in both cases; `busy`=0, `done`=0.
- **Small product:** MULTU for 1 cycle with dataA=3, dataB=5, then Signal=0.
  - `busy` high for exactly 32 cycles, `done` pulses once at cycle 33.
  - MFLO → 0x0000000F, MFHI → 0x00000000.
- **Maximum operands:** dataA=dataB=0xFFFFFFFF → MFHI 0xFFFFFFFE, MFLO 0x00000001.
- **Interference:** start with 0x80000000 × 2. At cycle 5 issue MULTU with 7 × 7 and also change dataA/dataB. During RUN, MFLO returns the prior LO.
  - Final result: HI=0x00000001, LO=0x00000000. The second request is ignored.
- **Reset mid-operation:** start 0x12345678 × 0x9ABCDEF0 and assert reset at RUN cycle 10.
  - Next cycle: IDLE, HI=LO=0, `busy`=0, and no `done` pulse ever follows.
- **Back-to-back:** hold MULTU with dataA=0x10000, dataB=0x10000.
  - `done` pulses every 34 cycles; HI=0x00000001, LO=0x00000000.
